brr_encoder: RTL and testbench

Streaming BRR (bit-rate-reduction) encoder for the APU audio path. It converts signed 16-bit PCM into 9-byte BRR blocks: one header byte and 8 data bytes carrying 16 four-bit samples. The output stream can be decoded back by the DSP channel voice decoder. It sits between a PCM source (echo capture or debug sample injection) and the ARAM write port, and supplies an ARAM byte address for every output byte. Only filter 0 is produced.

---
 rtl/brr_encoder.sv | 149 ++++++++++++++
 tb/tb_brr_encoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/brr_encoder.sv
// Streaming signed-16 PCM to BRR block encoder (filter 0) with ARAM byte addressing.
// Optional macro BRR_ENC_ROUND_EN selects round-to-nearest quantisation with saturation.
module brr_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_en,
   input  logic        start,
   input  logic [15:0] base_addr,
   input  logic        loop_en,
   input  logic [15:0] pcm_in,
   input  logic        pcm_valid,
   input  logic        pcm_last,
   output logic        pcm_ready,
   output logic [7:0]  out_data,
   output logic [15:0] out_addr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        block_done
);
   localparam int unsigned SAMPLE_W = 15;
   localparam int unsigned BLOCK_N  = 16;

   typedef enum logic [1:0] {FILL, PAD, HEADER, DATA} state_t;

   state_t                     state;
   logic signed [SAMPLE_W-1:0] sbuf [BLOCK_N];
   logic [3:0]                 idx;
   logic [3:0]                 blk_shift;
   logic [2:0]                 n;
   logic                       end_flg;
   logic signed [SAMPLE_W-1:0] y;
   logic [3:0]                 y_shift;
   logic [3:0]                 next_shift;

   // Smallest shift s in 1..12 such that the sample fits in s+3 signed bits.
   function automatic logic [3:0] need_shift(input logic signed [14:0] v);
      logic [14:0] mag;
      logic [3:0]  s;
      mag = v[14] ? {1'b0, ~v[13:0]} : {1'b0, v[13:0]};
      s   = 4'd12;
      for (int k = 12; k >= 1; k--)
         if (mag < (15'd1 << (k + 2))) s = 4'(k);
      return s;
   endfunction

   function automatic logic [3:0] quant(input logic signed [14:0] v, input logic [3:0] sh);
`ifdef BRR_ENC_ROUND_EN
      logic signed [15:0] a;
      logic signed [15:0] t;
      if (sh < 4'd2) return v[3:0];
      a = {v[14], v} + (16'sd1 <<< (sh - 4'd2));
      t = a >>> (sh - 4'd1);
      if (t > 16'sd7) return 4'd7;
      if (t < -16'sd8) return 4'b1000;
      return t[3:0];
`else
      logic signed [14:0] t;
      t = v >>> (sh - 4'd1);
      return t[3:0];
`endif
   endfunction

   assign y          = pcm_in[15:1];
   assign y_shift    = need_shift(y);
   assign next_shift = (y_shift > blk_shift) ? y_shift : blk_shift;

   // Header carries loop_en live; data nibbles are quantised from the buffer on the fly.
   always_comb begin
      out_data = 8'h00;
      case (state)
         HEADER:  out_data = {blk_shift, 2'b00, loop_en, end_flg};
         DATA:    out_data = {quant(sbuf[{n, 1'b0}], blk_shift),
                              quant(sbuf[{n, 1'b1}], blk_shift)};
         default: out_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= FILL;
         pcm_ready  <= 1'b1;
         out_valid  <= 1'b0;
         out_addr   <= 16'h0000;
         block_done <= 1'b0;
         idx        <= 4'd0;
         blk_shift  <= 4'd1;
         end_flg    <= 1'b0;
         n          <= 3'd0;
         for (int unsigned i = 0; i < BLOCK_N; i++) sbuf[i] <= '0;
      end else begin
         block_done <= 1'b0;
         if (cpu_en) begin
            if (start) begin
               state     <= FILL;
               pcm_ready <= 1'b1;
               out_valid <= 1'b0;
               out_addr  <= base_addr;
               idx       <= 4'd0;
               blk_shift <= 4'd1;
               end_flg   <= 1'b0;
            end else begin
               case (state)
                  FILL: if (pcm_valid) begin
                     sbuf[idx] <= y;
                     idx       <= idx + 4'd1;
                     blk_shift <= next_shift;
                     if (pcm_last) end_flg <= 1'b1;
                     if (idx == 4'd15) begin
                        state     <= HEADER;
                        pcm_ready <= 1'b0;
                        out_valid <= 1'b1;
                     end else if (pcm_last) begin
                        state     <= PAD;
                        pcm_ready <= 1'b0;
                     end
                  end
                  PAD: begin
                     sbuf[idx] <= '0;
                     idx       <= idx + 4'd1;
                     if (idx == 4'd15) begin
                        state     <= HEADER;
                        out_valid <= 1'b1;
                     end
                  end
                  HEADER: if (out_ready) begin
                     out_addr <= out_addr + 16'd1;
                     n        <= 3'd0;
                     state    <= DATA;
                  end
                  DATA: if (out_ready) begin
                     out_addr <= out_addr + 16'd1;
                     n        <= n + 3'd1;
                     if (n == 3'd7) begin
                        block_done <= 1'b1;
                        idx        <= 4'd0;
                        blk_shift  <= 4'd1;
                        end_flg    <= 1'b0;
                        state      <= FILL;
                        pcm_ready  <= 1'b1;
                        out_valid  <= 1'b0;
                     end
                  end
                  default: state <= FILL;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_brr_encoder.sv
// Directed bench for brr_encoder: an independent block model fills a byte scoreboard
// that is checked against the output stream, plus reset/start/stall/pad/wrap cases.
module tb_brr_encoder;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_en;
   logic        start;
   logic [15:0] base_addr;
   logic        loop_en;
   logic [15:0] pcm_in;
   logic        pcm_valid;
   logic        pcm_last;
   logic        pcm_ready;
   logic [7:0]  out_data;
   logic [15:0] out_addr;
   logic        out_valid;
   logic        out_ready;
   logic        block_done;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      bit          last;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] exp_addr = 16'h0000;
   logic [15:0] smp [16];
   int          errors = 0;
   int          checks = 0;
   int          div = 0;

   brr_encoder dut (
      .clk(clk), .reset(reset), .cpu_en(cpu_en), .start(start), .base_addr(base_addr),
      .loop_en(loop_en), .pcm_in(pcm_in), .pcm_valid(pcm_valid), .pcm_last(pcm_last),
      .pcm_ready(pcm_ready), .out_data(out_data), .out_addr(out_addr),
      .out_valid(out_valid), .out_ready(out_ready), .block_done(block_done)
   );

   always #5 clk = ~clk;
   always @(negedge clk) div <= (div == 3) ? 0 : div + 1;
   assign cpu_en = (div == 0);

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   // Advance to just after the next cpu_en-qualified clock edge.
   task automatic next();
      do @(posedge clk); while (cpu_en !== 1'b1);
      #1;
   endtask

   function automatic logic [3:0] qm(input int v, input int sh);
      int t;
`ifdef BRR_ENC_ROUND_EN
      if (sh == 1) t = v;
      else t = (v + (1 << (sh - 2))) >>> (sh - 1);
      if (t > 7) t = 7;
      if (t < -8) t = -8;
`else
      t = v >>> (sh - 1);
`endif
      return 4'(t);
   endfunction

   task automatic push(input logic [7:0] d, input bit l);
      exp_q.push_back('{addr: exp_addr, data: d, last: l});
      exp_addr = exp_addr + 16'd1;
   endtask

   // Model one block from smp[0..nvalid-1], zero padded.
   task automatic push_block(input int nvalid, input bit lastv, input bit loopv);
      int ys[16];
      int sh;
      int s;
      logic [14:0] raw;
      sh = 1;
      for (int i = 0; i < 16; i++) begin
         raw   = smp[i][15:1];
         ys[i] = (i < nvalid) ? int'($signed(raw)) : 0;
         s = 1;
         while (s < 12 && !(ys[i] >= -(1 << (s + 2)) && ys[i] < (1 << (s + 2)))) s++;
         if (s > sh) sh = s;
      end
      push({4'(sh), 2'b00, loopv, lastv}, 1'b0);
      for (int j = 0; j < 8; j++) push({qm(ys[2*j], sh), qm(ys[2*j+1], sh)}, j == 7);
   endtask

   task automatic fill(input logic [15:0] v);
      for (int i = 0; i < 16; i++) smp[i] = v;
   endtask

   task automatic send(input int cnt, input bit lastv);
      for (int i = 0; i < cnt; i++) begin
         pcm_in    = smp[i];
         pcm_valid = 1'b1;
         pcm_last  = lastv && (i == cnt - 1);
         chk("pcm_ready_fill", pcm_ready, 1);
         next();
      end
      pcm_valid = 1'b0;
      pcm_last  = 1'b0;
   endtask

   task automatic drain(input int nbytes, input bit toggle);
      exp_t e;
      int   got = 0;
      int   guard = 0;
      bit   rdy = 1'b1;
      while (got < nbytes && guard < 100) begin
         out_ready = rdy;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=%0d", nbytes - got);
            break;
         end
         e = exp_q[0];
         chk("out_valid", out_valid, 1);
         chk("out_data", out_data, e.data);
         chk("out_addr", out_addr, e.addr);
         next();
         if (rdy) begin
            void'(exp_q.pop_front());
            chk("block_done", block_done, e.last);
            got++;
         end
         if (toggle) rdy = ~rdy;
         guard++;
      end
      out_ready = 1'b1;
      if (got < nbytes) begin
         checks++;
         errors++;
         $error("FAIL drain_timeout observed=%0d expected=%0d", got, nbytes);
      end
   endtask

   task automatic do_start(input logic [15:0] a);
      base_addr = a;
      start     = 1'b1;
      next();
      start     = 1'b0;
      exp_q.delete();
      exp_addr  = a;
   endtask

   initial begin
      logic signed [15:0] r;
      start = 0; base_addr = 0; loop_en = 0; pcm_in = 0; pcm_valid = 0; pcm_last = 0;
      out_ready = 1;
      #23;
      chk("rst_pcm_ready", pcm_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_out_addr", out_addr, 16'h0000);
      chk("rst_block_done", block_done, 0);
      reset = 1'b0;
      next();

      // silence block
      do_start(16'h1000);
      fill(16'h0000); send(16, 0); push_block(16, 0, 0); drain(9, 0);

      // full-scale positive then negative
      do_start(16'h3000);
      fill(16'h7FFE); send(16, 0); push_block(16, 0, 0); drain(9, 0);
      fill(16'h8000); send(16, 0); push_block(16, 0, 0); drain(9, 0);

      // small value, shift 2
      fill(16'h0016); send(16, 0); push_block(16, 0, 0); drain(9, 0);

      // short stream with padding and loop flag
      loop_en = 1'b1;
      fill(16'h0014); send(3, 1);
      for (int i = 0; i < 13; i++) begin
         chk("pad_pcm_ready", pcm_ready, 0);
         chk("pad_out_valid", out_valid, 0);
         next();
      end
      push_block(3, 1, 1); drain(9, 0);
      loop_en = 1'b0;

      // varied magnitudes with a stalling sink
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 16; i++) begin
            r = 16'($urandom);
            smp[i] = 16'(r >>> $urandom_range(0, 12));
         end
         send(16, 0); push_block(16, 0, 0); drain(9, 1);
      end

      // start mid-DATA discards the rest of the block
      fill(16'h5A5A); send(16, 0); push_block(16, 0, 0); drain(3, 0);
      out_ready = 1'b1;
      do_start(16'h2000);
      chk("start_out_valid", out_valid, 0);
      chk("start_pcm_ready", pcm_ready, 1);
      chk("start_block_done", block_done, 0);
      chk("start_out_data", out_data, 8'h00);
      fill(16'h0000); send(16, 0); push_block(16, 0, 0); drain(9, 0);

      // async reset mid-FILL
      fill(16'h0100); send(5, 0);
      #3 reset = 1'b1;
      #1;
      chk("arst_pcm_ready", pcm_ready, 1);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_data", out_data, 8'h00);
      chk("arst_out_addr", out_addr, 16'h0000);
      chk("arst_block_done", block_done, 0);
      #2 reset = 1'b0;
      next();
      exp_q.delete();
      exp_addr = 16'h0000;
      fill(16'h0016); send(16, 0); push_block(16, 0, 0); drain(9, 0);

      // address wrap across 0xFFFF
      do_start(16'hFFFB);
      fill(16'hFFF0); send(16, 0); push_block(16, 0, 0); drain(9, 0);
      chk("wrap_next_addr", out_addr, 16'h0004);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
